// File: rtl/sin_seq_pkg.sv
// Shared types and sizing helpers for the sine burst sequencer.
package sin_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int pt_w(input int n_pts);
    return (n_pts > 1) ? $clog2(n_pts) : 1;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Loadable clock divider: counts 0..div-1, flags the terminal count as tick,
// and parks on terminal while the consumer cannot take the tick.
module tick_div #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic                 hold,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] term;

  assign term = div - DIV_WIDTH'(1);
  assign tick = en && (cnt == term);

  // divider count; load presets terminal so the first enabled cycle ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= term;
    end else if (en) begin
      if (cnt == term) begin
        if (!hold) begin
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/axis_sin_seq.sv
// Burst sequencer for the sine generator: paces phase steps from a divider,
// counts points/waves, and forwards samples on an AXI-Stream master.
module axis_sin_seq
  import sin_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_PTS      = 50,
  parameter int DIV_WIDTH  = 16,
  parameter int WAVE_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [WAVE_WIDTH-1:0] cfg_n_waves,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic                  gen_clr,
  output logic                  gen_step,
  input  logic [DATA_WIDTH-1:0] gen_data,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready
);

  localparam int              PT_W    = pt_w(N_PTS);
  localparam logic [PT_W-1:0] PT_LAST = PT_W'(N_PTS - 1);

  state_t                state;
  logic [DIV_WIDTH-1:0]  div_lat;
  logic [WAVE_WIDTH-1:0] waves_lat;
  logic [PT_W-1:0]       pt_cnt;
  logic [WAVE_WIDTH-1:0] wave_cnt;
  logic                  inflight;
  logic                  tick;
  logic                  out_free;
  logic                  step;
  logic                  last_step;
  logic                  drain_ok;

  // step interlock and end-of-burst decode
  always_comb begin
    out_free  = !m_axis_data_tvalid || m_axis_data_tready;
    step      = (state == RUN) && tick && !inflight && out_free && !stop;
    last_step = step && (pt_cnt == PT_LAST) && (waves_lat != '0) &&
                (wave_cnt == waves_lat - WAVE_WIDTH'(1));
    // drain finishes once the output register will be empty next cycle
    drain_ok  = !inflight && !(m_axis_data_tvalid && !m_axis_data_tready);
  end

  assign gen_step = step;

  tick_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_div (
    .clk  (aclk),
    .rst  (rst),
    .load (state == ARM),
    .en   (state == RUN),
    .hold (!step),
    .div  (div_lat),
    .tick (tick)
  );

  // sequencer FSM, config latch and point/wave counters
  always_ff @(posedge aclk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_clr   <= 1'b0;
      div_lat   <= '0;
      waves_lat <= '0;
      pt_cnt    <= '0;
      wave_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      gen_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            busy      <= 1'b1;
            gen_clr   <= 1'b1;
            div_lat   <= (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
            waves_lat <= cfg_n_waves;
          end else begin
            // busy trails done by one cycle
            busy <= 1'b0;
          end
        end
        ARM: begin
          pt_cnt   <= '0;
          wave_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
          end else if (step) begin
            if (pt_cnt == PT_LAST) begin
              pt_cnt   <= '0;
              wave_cnt <= wave_cnt + WAVE_WIDTH'(1);
            end else begin
              pt_cnt <= pt_cnt + PT_W'(1);
            end
            if (last_step) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // single-entry output register fed one cycle after each step
  always_ff @(posedge aclk) begin
    if (rst) begin
      inflight           <= 1'b0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
    end else begin
      inflight <= step;
      if (inflight) begin
        m_axis_data_tdata  <= gen_data;
        m_axis_data_tvalid <= 1'b1;
      end else if (m_axis_data_tready) begin
        m_axis_data_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_sin_seq.sv
// Scoreboard bench for axis_sin_seq with a behavioural generator model.
module tb_axis_sin_seq;

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'd0;
  logic [15:0] cfg_n_waves = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, gen_clr, gen_step;
  logic [15:0] gen_data = 16'd0;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;

  always #5 aclk = ~aclk;

  axis_sin_seq dut (
    .aclk               (aclk),
    .rst                (rst),
    .cfg_div            (cfg_div),
    .cfg_n_waves        (cfg_n_waves),
    .start              (start),
    .stop               (stop),
    .busy               (busy),
    .done               (done),
    .gen_clr            (gen_clr),
    .gen_step           (gen_step),
    .gen_data           (gen_data),
    .m_axis_data_tdata  (tdata),
    .m_axis_data_tvalid (tvalid),
    .m_axis_data_tready (tready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] smp(input int p);
    return 16'h1234 + 16'(p * 611);
  endfunction

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // generator model: sample for the current phase appears the cycle after a step
  int phase = 0;
  always @(posedge aclk) begin
    if (gen_clr) begin
      phase <= 0;
    end else if (gen_step) begin
      gen_data <= smp(phase);
      phase    <= (phase + 1) % 50;
    end
  end

  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 0)      tready = 1'b1;
      else if (rdy_mode == 1) tready = ((cyc % 3) == 0);
      else                    tready = 1'b0;
    end
  end

  // monitor / scoreboard
  int          step_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] beat_log[$];
  int          done_cnt = 0, done_cyc = 0, clr_cnt = 0, clr_cyc = 0;
  logic        busy_at_done = 1'b0, busy_after = 1'b0;
  logic        prev_stall = 1'b0, prev_done = 1'b0;
  logic [15:0] prev_data = 16'd0;

  always @(negedge aclk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", 32'(tdata), 32'(prev_data));
        check("stall_valid", 32'(tvalid), 1);
      end
      if (tvalid && !tready) check("no_step_stall", 32'(gen_step), 0);
      if (gen_step) begin
        step_q.push_back(cyc);
        exp_q.push_back(smp(phase));
      end
      if (gen_clr) begin
        clr_cnt++;
        clr_cyc = cyc;
      end
      if (tvalid && tready) begin
        beat_log.push_back(tdata);
        if (exp_q.size() == 0) check("sb_nonempty", exp_q.size(), 1);
        else check("beat_data", 32'(tdata), 32'(exp_q.pop_front()));
      end
      if (prev_done) busy_after = busy;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      prev_done  = done;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
    end
  end

  task automatic do_start(input logic [15:0] div, input logic [15:0] waves, output int k);
    @(posedge aclk);
    #1;
    cfg_div     = div;
    cfg_n_waves = waves;
    start       = 1'b1;
    k           = cyc;
    @(posedge aclk);
    #1;
    start       = 1'b0;
    cfg_div     = 16'd7;
    cfg_n_waves = 16'd5;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (done_cnt != d0) break;
    end
    check("done_once", done_cnt - d0, 1);
    repeat (6) @(negedge aclk);
    check("done_no_repeat", done_cnt - d0, 1);
  endtask

  task automatic wait_steps(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (step_q.size() >= target) break;
    end
    check("steps_reached", 32'(step_q.size() >= target), 1);
  endtask

  initial begin
    int k, s0, b0, c0;

    // reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_gen_clr", 32'(gen_clr), 0);
    check("rst_gen_step", 32'(gen_step), 0);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    @(posedge aclk);
    #1 rst = 1'b0;
    repeat (3) @(posedge aclk);

    // two waves, div 10, no backpressure: exact timing
    s0 = step_q.size(); b0 = beat_log.size();
    do_start(16'd10, 16'd2, k);
    wait_done(1500);
    check("t2_clr_cyc", clr_cyc, k + 1);
    check("t2_steps", step_q.size() - s0, 100);
    for (int m = 0; m < 100 && s0 + m < step_q.size(); m++)
      check("t2_step_cyc", step_q[s0 + m], k + 2 + 10 * m);
    check("t2_beats", beat_log.size() - b0, 100);
    check("t2_done_cyc", done_cyc, k + 995);
    check("t2_busy_at_done", 32'(busy_at_done), 1);
    check("t2_busy_after", 32'(busy_after), 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // same burst under 1-of-3 ready
    rdy_mode = 1;
    s0 = step_q.size(); b0 = beat_log.size();
    do_start(16'd10, 16'd2, k);
    wait_done(4000);
    check("t3_steps", step_q.size() - s0, 100);
    check("t3_beats", beat_log.size() - b0, 100);
    check("t3_sb_empty", exp_q.size(), 0);
    rdy_mode = 0;
    repeat (2) @(posedge aclk);

    // continuous, div 4, stopped at point 17 of the second wave
    s0 = step_q.size(); b0 = beat_log.size();
    do_start(16'd4, 16'd0, k);
    wait_steps(s0 + 67, 1000);
    @(posedge aclk);
    #1 stop = 1'b1;
    @(posedge aclk);
    #1 stop = 1'b0;
    wait_done(200);
    repeat (20) @(negedge aclk);
    check("t4_steps", step_q.size() - s0, 67);
    check("t4_first", step_q[s0], k + 2);
    for (int m = 1; m < 67 && s0 + m < step_q.size(); m++)
      check("t4_interval", step_q[s0 + m] - step_q[s0 + m - 1], 4);
    check("t4_beats", beat_log.size() - b0, 67);
    check("t4_sb_empty", exp_q.size(), 0);

    // div 0 and div 1 both limited to one step per 2 cycles
    for (int d = 0; d < 2; d++) begin
      s0 = step_q.size(); b0 = beat_log.size();
      do_start(16'(d), 16'd1, k);
      wait_done(500);
      check("t5_steps", step_q.size() - s0, 50);
      check("t5_first", step_q[s0], k + 2);
      for (int m = 1; m < 50 && s0 + m < step_q.size(); m++)
        check("t5_interval", step_q[s0 + m] - step_q[s0 + m - 1], 2);
      check("t5_beats", beat_log.size() - b0, 50);
    end

    // start+stop together starts; restart while running is ignored
    s0 = step_q.size(); b0 = beat_log.size(); c0 = clr_cnt;
    @(posedge aclk);
    #1;
    cfg_div = 16'd2; cfg_n_waves = 16'd1; start = 1'b1; stop = 1'b1; k = cyc;
    @(posedge aclk);
    #1 start = 1'b0; stop = 1'b0;
    wait_steps(s0 + 10, 200);
    @(posedge aclk);
    #1 cfg_div = 16'd5; cfg_n_waves = 16'd3; start = 1'b1;
    @(posedge aclk);
    #1 start = 1'b0;
    wait_done(500);
    check("t6_clr_cnt", clr_cnt - c0, 1);
    check("t6_clr_cyc", clr_cyc, k + 1);
    check("t6_steps", step_q.size() - s0, 50);
    for (int m = 1; m < 50 && s0 + m < step_q.size(); m++)
      check("t6_interval", step_q[s0 + m] - step_q[s0 + m - 1], 2);
    check("t6_beats", beat_log.size() - b0, 50);

    // reset mid-burst with a stalled beat, then clean replay
    s0 = step_q.size();
    do_start(16'd3, 16'd1, k);
    wait_steps(s0 + 5, 200);
    rdy_mode = 2;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (tvalid && !tready) break;
    end
    check("t7_stalled", 32'(tvalid && !tready), 1);
    @(posedge aclk);
    #1 rst = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("t7_tvalid", 32'(tvalid), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_step", 32'(gen_step), 0);
    @(posedge aclk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    repeat (3) @(posedge aclk);
    s0 = step_q.size(); b0 = beat_log.size();
    do_start(16'd2, 16'd1, k);
    wait_done(500);
    check("t7_steps", step_q.size() - s0, 50);
    check("t7_beats", beat_log.size() - b0, 50);
    if (beat_log.size() > b0) check("t7_first_data", 32'(beat_log[b0]), 32'(smp(0)));
    else check("t7_first_data_present", beat_log.size() - b0, 1);
    check("t7_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
